rr_arbiter3: RTL and testbench
==============================

Name: rr_arbiter3

Overview:
- Round-robin arbiter that shares one 3-input datapath resource (e.g. the writeback/ALU-source 3:1 selector or a shared memory port) among three requesters.
- Registers a one-hot grant and drives the matching 2-bit select code to the mux.
- Enforces a maximum hold time so that no requester can starve the others.
- Sits between requesting units (CPU core, debug/IO unit, DMA-style loader) and the shared mux.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one owner may hold the grant while another requester waits. 0 disables preemption.
- CNT_W, 5: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  3  request per requester; held high for as long as the resource is wanted
- grant  output  3  registered one-hot grant; 3'b000 when idle
- sel  output  2  mux select: 2'b00/01/10 = requester 0/1/2; 2'b11 when idle (mux outputs 0)
- busy  output  1  high whenever any grant is active
- preempt  output  1  one-cycle pulse when a grant is forcibly revoked by timeout
- hold_cnt  output  CNT_W  cycles the current owner has held the grant; 0 when idle

Behaviour:
- Reset: asynchronous and immediate, including mid-grant.
  - grant=000, sel=11, busy=0, preempt=0, hold_cnt=0, state=IDLE.
  - last_owner=2, so requester 0 has first priority after reset.
- All outputs are registered. sel, busy and grant are always consistent in the same cycle.
- Round-robin order: search starts at last_owner+1 mod 3 and wraps around; the first asserted req wins.
- State IDLE:
  - If req==000, stay in IDLE.
  - Otherwise, grant the round-robin winner on the next edge. Latency is 1 cycle from req to grant.
  - On entering OWN: hold_cnt=0 and last_owner=winner.
- State OWN (owner o):
  - Each cycle with req[o]=1: hold_cnt increments, saturating at MAX_HOLD.
  - Release: req[o]=0 at an edge.
    - If any other req is high, grant the next round-robin winner at that same edge. There is no idle bubble; hold_cnt=0.
    - Otherwise go to IDLE: grant=000, sel=11.
  - Timeout: MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, req[o]=1, and at least one other req high.
    - At the next edge, grant the next round-robin winner (excluding o).
    - preempt=1 for exactly that one cycle; hold_cnt=0.
  - Timeout with no other requester: keep the grant; hold_cnt saturates at MAX_HOLD; no preempt.
    - If another request arrives while saturated, hand off at the next edge with a preempt pulse.
  - A preempted owner that keeps req high re-enters round-robin arbitration normally. It gets its next turn after the others.
- Simultaneous events:
  - Release and timeout in the same cycle count as a release; no preempt.
  - New requests arriving in the same cycle as a release are eligible for that handoff.
- A req that drops before it is granted is simply not considered. No request is latched.
- grant is never multi-hot. sel never equals 11 while busy=1.

Test Plan:
- Reset with req=111 → first grant=001/sel=00 one cycle after rst falls. Release 0 → grant=010 on the next cycle. Release 1 → grant=100.
- Single requester 1 holding for 40 cycles, others idle, MAX_HOLD=16 → grant stays 010, hold_cnt saturates at 16, preempt never pulses. Drop req → grant=000, sel=11 next cycle.
- req0 held continuously, req2 raised at cycle 3 of ownership → handoff to 100 exactly when hold_cnt reaches 15. preempt=1 for one cycle. req0 regranted only after req2 releases.
- Back-to-back: owner 2 releases in the same cycle that req0 and req1 are high → grant=001 at the next edge (wrap 2→0), with no IDLE cycle between grants.
- Assert rst asynchronously mid-grant (between clock edges) → grant=000, sel=11, busy=0 immediately. After release, req=010 → grant=010 after 1 cycle.
- MAX_HOLD=0 build, req0 held 100 cycles with req1 high → no preemption; grant stays 001 until req0 drops, then 010.

Source files
------------

// File: rtl/rr_arbiter3.sv
// rr_arbiter3: round-robin arbiter for one shared 3-input datapath resource.
// A registered one-hot grant and its 2-bit mux select are issued. A hold-time
// limit stops one owner from starving the others.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   req[2:0]  per-requester request, held high while the resource is wanted
//   grant     registered one-hot grant, 3'b000 when idle
//   sel       mux select 0/1/2 for the owner, 2'b11 when idle
//   busy      high while any grant is active
//   preempt   one-cycle pulse when a grant is revoked by timeout
//   hold_cnt  cycles the current owner has held the grant, 0 when idle
module rr_arbiter3 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       req,
    output logic [2:0]       grant,
    output logic [1:0]       sel,
    output logic             busy,
    output logic             preempt,
    output logic [CNT_W-1:0] hold_cnt
);

    // A hold count at this value with a waiting requester triggers handoff.
    localparam int unsigned HOLD_LIM = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

    typedef enum logic {
        S_IDLE,
        S_OWN
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       last_q, last_d;      // current owner, or last owner when idle
    logic [2:0]       grant_q, grant_d;
    logic [1:0]       sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             preempt_q, preempt_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    // Round-robin pick: search from last+1 with wraparound. Returns {valid, index}.
    function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [2:0] pick;
        logic [2:0] s;
        pick = 3'b000;
        for (int unsigned k = 1; k <= 3; k++) begin
            s = 3'({1'b0, last} + 3'(k));
            if (s >= 3'd3) s = s - 3'd3;
            if (!pick[2] && r[s[1:0]]) pick = {1'b1, s[1:0]};
        end
        return pick;
    endfunction

    logic [2:0] pick_all;
    logic [2:0] pick_oth;
    logic       own_req;
    logic       timeout;
    logic       do_grant;
    logic [1:0] grant_idx;

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        preempt_d = 1'b0;
        hold_d    = hold_q;
        do_grant  = 1'b0;
        grant_idx = 2'd0;

        pick_all = rr_pick(req, last_q);
        // Excluding the owner keeps a preempted owner from winning its own handoff.
        pick_oth = rr_pick(req & ~(3'b001 << last_q), last_q);
        own_req  = req[last_q];
        timeout  = (MAX_HOLD != 0) && (hold_q >= CNT_W'(HOLD_LIM));

        case (state_q)
            S_IDLE: begin
                if (pick_all[2]) begin
                    do_grant  = 1'b1;
                    grant_idx = pick_all[1:0];
                end
            end
            S_OWN: begin
                if (!own_req) begin
                    // Release wins over a simultaneous timeout: no preempt.
                    if (pick_all[2]) begin
                        do_grant  = 1'b1;
                        grant_idx = pick_all[1:0];
                    end else begin
                        state_d = S_IDLE;
                        grant_d = 3'b000;
                        sel_d   = 2'b11;
                        busy_d  = 1'b0;
                        hold_d  = '0;
                    end
                end else if (timeout && pick_oth[2]) begin
                    do_grant  = 1'b1;
                    grant_idx = pick_oth[1:0];
                    preempt_d = 1'b1;
                end else if (hold_q < CNT_W'(MAX_HOLD)) begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (do_grant) begin
            state_d = S_OWN;
            last_d  = grant_idx;
            grant_d = 3'b001 << grant_idx;
            sel_d   = grant_idx;
            busy_d  = 1'b1;
            hold_d  = '0;
        end
    end

    // State and output registers; last owner resets to 2 so requester 0 goes first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            last_q    <= 2'd2;
            grant_q   <= 3'b000;
            sel_q     <= 2'b11;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
            hold_q    <= hold_d;
        end
    end

    assign grant    = grant_q;
    assign sel      = sel_q;
    assign busy     = busy_q;
    assign preempt  = preempt_q;
    assign hold_cnt = hold_q;

endmodule

// File: tb/tb_rr_arbiter3.sv
// Self-checking bench for rr_arbiter3: a default build (MAX_HOLD=16) and a
// MAX_HOLD=0 build run from one clock with shared reset.
module tb_rr_arbiter3;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [2:0] req_z;

    logic [2:0] grant, grant_z;
    logic [1:0] sel, sel_z;
    logic       busy, busy_z;
    logic       preempt, preempt_z;
    logic [4:0] hold_cnt, hold_cnt_z;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_arbiter3 #(.MAX_HOLD(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .req(req),
        .grant(grant), .sel(sel), .busy(busy), .preempt(preempt), .hold_cnt(hold_cnt)
    );

    rr_arbiter3 #(.MAX_HOLD(0), .CNT_W(5)) dut_z (
        .clk(clk), .rst(rst), .req(req_z),
        .grant(grant_z), .sel(sel_z), .busy(busy_z), .preempt(preempt_z), .hold_cnt(hold_cnt_z)
    );

    typedef struct {
        logic [2:0] req;
        logic [2:0] grant;
        logic       preempt;
        int unsigned hold;
    } vec_t;

    typedef struct {
        string      name;
        bit         z;
        logic [2:0] grant;
        logic [1:0] sel;
        logic       busy;
        logic       preempt;
        logic [4:0] hold;
    } exp_t;

    exp_t sb[$];

    function automatic logic [1:0] exp_sel(input logic [2:0] g);
        case (g)
            3'b001:  return 2'd0;
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic int unsigned min16(input int unsigned i);
        return (i > 16) ? 16 : i;
    endfunction

    task automatic push_exp(input string nm, input bit z, input logic [2:0] g,
                            input logic p, input int unsigned h);
        exp_t e;
        e.name    = nm;
        e.z       = z;
        e.grant   = g;
        e.sel     = exp_sel(g);
        e.busy    = (g != 3'b000);
        e.preempt = p;
        e.hold    = 5'(h);
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        logic [2:0] ag;
        logic [1:0] as;
        logic       ab, ap;
        logic [4:0] ah;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_empty: nothing expected at t=%0t", $time);
            return;
        end
        e = sb.pop_front();
        if (e.z) begin
            ag = grant_z; as = sel_z; ab = busy_z; ap = preempt_z; ah = hold_cnt_z;
        end else begin
            ag = grant; as = sel; ab = busy; ap = preempt; ah = hold_cnt;
        end
        n_cmp++;
        if (ag !== e.grant || as !== e.sel || ab !== e.busy || ap !== e.preempt || ah !== e.hold) begin
            n_err++;
            $display("FAIL %s t=%0t: got grant=%b sel=%b busy=%b preempt=%b hold=%0d, want grant=%b sel=%b busy=%b preempt=%b hold=%0d",
                     e.name, $time, ag, as, ab, ap, ah, e.grant, e.sel, e.busy, e.preempt, e.hold);
        end
    endtask

    // Drive req for one cycle, then compare outputs 1 time unit after the edge.
    task automatic step(input string nm, input bit z, input logic [2:0] r,
                        input logic [2:0] g, input logic p, input int unsigned h);
        if (z) req_z = r;
        else   req   = r;
        push_exp(nm, z, g, p, h);
        @(posedge clk);
        #1;
        check_out();
    endtask

    vec_t tbl[17];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // {req, expected grant, preempt, hold_cnt} for the round-robin basics
        tbl[0]  = '{3'b111, 3'b001, 1'b0, 0};
        tbl[1]  = '{3'b110, 3'b010, 1'b0, 0};
        tbl[2]  = '{3'b100, 3'b100, 1'b0, 0};
        tbl[3]  = '{3'b000, 3'b000, 1'b0, 0};
        tbl[4]  = '{3'b100, 3'b100, 1'b0, 0};
        tbl[5]  = '{3'b111, 3'b100, 1'b0, 1};
        tbl[6]  = '{3'b011, 3'b001, 1'b0, 0};
        tbl[7]  = '{3'b011, 3'b001, 1'b0, 1};
        tbl[8]  = '{3'b010, 3'b010, 1'b0, 0};
        tbl[9]  = '{3'b000, 3'b000, 1'b0, 0};
        tbl[10] = '{3'b101, 3'b100, 1'b0, 0};
        tbl[11] = '{3'b001, 3'b001, 1'b0, 0};
        tbl[12] = '{3'b000, 3'b000, 1'b0, 0};
        tbl[13] = '{3'b010, 3'b010, 1'b0, 0};
        tbl[14] = '{3'b011, 3'b010, 1'b0, 1};
        tbl[15] = '{3'b010, 3'b010, 1'b0, 2};
        tbl[16] = '{3'b000, 3'b000, 1'b0, 0};

        rst   = 1'b1;
        req   = 3'b111;
        req_z = 3'b000;
        #12;
        push_exp("reset_state", 0, 3'b000, 1'b0, 0);
        check_out();
        push_exp("reset_state_z", 1, 3'b000, 1'b0, 0);
        check_out();
        #1 rst = 1'b0;

        for (int i = 0; i < 17; i++)
            step($sformatf("table[%0d]", i), 0, tbl[i].req, tbl[i].grant, tbl[i].preempt, tbl[i].hold);

        // Lone requester: hold_cnt saturates at 16, no preempt, then idle on drop.
        step("solo_grant", 0, 3'b010, 3'b010, 1'b0, 0);
        for (int i = 1; i < 40; i++)
            step($sformatf("solo_hold[%0d]", i), 0, 3'b010, 3'b010, 1'b0, min16(i));
        step("solo_drop", 0, 3'b000, 3'b000, 1'b0, 0);

        // Saturated owner is preempted as soon as another request shows up.
        step("sat_grant", 0, 3'b010, 3'b010, 1'b0, 0);
        for (int i = 1; i <= 20; i++)
            step($sformatf("sat_hold[%0d]", i), 0, 3'b010, 3'b010, 1'b0, min16(i));
        step("sat_preempt", 0, 3'b011, 3'b001, 1'b1, 0);
        step("sat_idle", 0, 3'b000, 3'b000, 1'b0, 0);

        // req0 held, req2 raised at cycle 3; handoff after hold_cnt reaches 15.
        step("to_grant", 0, 3'b001, 3'b001, 1'b0, 0);
        for (int i = 1; i <= 2; i++)
            step($sformatf("to_solo[%0d]", i), 0, 3'b001, 3'b001, 1'b0, i);
        for (int i = 3; i <= 15; i++)
            step($sformatf("to_wait[%0d]", i), 0, 3'b101, 3'b001, 1'b0, i);
        step("to_preempt", 0, 3'b101, 3'b100, 1'b1, 0);
        step("to_after1", 0, 3'b101, 3'b100, 1'b0, 1);
        step("to_after2", 0, 3'b101, 3'b100, 1'b0, 2);
        step("to_regrant0", 0, 3'b001, 3'b001, 1'b0, 0);
        step("to_idle", 0, 3'b000, 3'b000, 1'b0, 0);

        // Release in the same cycle as the timeout counts as a release.
        step("rt_grant", 0, 3'b001, 3'b001, 1'b0, 0);
        for (int i = 1; i <= 15; i++)
            step($sformatf("rt_hold[%0d]", i), 0, 3'b011, 3'b001, 1'b0, i);
        step("rt_release", 0, 3'b010, 3'b010, 1'b0, 0);
        step("rt_idle", 0, 3'b000, 3'b000, 1'b0, 0);

        // Asynchronous reset between edges while a grant is active.
        step("ar_grant", 0, 3'b100, 3'b100, 1'b0, 0);
        step("ar_hold", 0, 3'b100, 3'b100, 1'b0, 1);
        #2 rst = 1'b1;
        #1;
        push_exp("ar_immediate", 0, 3'b000, 1'b0, 0);
        check_out();
        @(posedge clk);
        #1 rst = 1'b0;
        step("ar_after", 0, 3'b010, 3'b010, 1'b0, 0);
        step("ar_idle", 0, 3'b000, 3'b000, 1'b0, 0);

        // MAX_HOLD=0 build: no preemption no matter how long req0 is held.
        step("z_grant", 1, 3'b011, 3'b001, 1'b0, 0);
        for (int i = 1; i < 100; i++)
            step($sformatf("z_hold[%0d]", i), 1, 3'b011, 3'b001, 1'b0, 0);
        step("z_handoff", 1, 3'b010, 3'b010, 1'b0, 0);
        step("z_idle", 1, 3'b000, 3'b000, 1'b0, 0);

        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_leftover: %0d entries remain, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
